// File: rtl/adder_slice_seq.sv
// Multi-cycle adder: computes a WIDTH-bit a+b+cin by sending one SLICE-bit slice per clock
// through an external ripple-carry slice, LSB first, with the carry held in a register.
module adder_slice_seq #(
    parameter int SLICE  = 3,
    parameter int NSLICE = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [SLICE*NSLICE-1:0]   a,
    input  logic [SLICE*NSLICE-1:0]   b,
    input  logic                      cin,
    output logic                      busy,
    output logic                      done,
    output logic [SLICE*NSLICE-1:0]   sum,
    output logic                      cout,
    output logic [SLICE-1:0]          slc_a,
    output logic [SLICE-1:0]          slc_b,
    output logic                      slc_cin,
    input  logic [SLICE-1:0]          slc_sum,
    input  logic                      slc_cout
);

    localparam int WIDTH = SLICE * NSLICE;
    localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (idx == IDX_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // idx holds at the last slice so it never wraps past NSLICE-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        idx   <= '0;
                        carry <= cin;
                        sum   <= '0;
                        cout  <= 1'b0;
                    end
                end
                RUN: begin
                    sum[idx*SLICE +: SLICE] <= slc_sum;
                    carry                   <= slc_cout;
                    if (idx == IDX_LAST) begin
                        cout <= slc_cout;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy    = (state == RUN);
        done    = (state == DONE);
        slc_a   = '0;
        slc_b   = '0;
        slc_cin = 1'b0;
        if (state == RUN) begin
            slc_a   = a_reg[idx*SLICE +: SLICE];
            slc_b   = b_reg[idx*SLICE +: SLICE];
            slc_cin = carry;
        end
    end

endmodule

// File: tb/tb_adder_slice_seq.sv
// Bench for adder_slice_seq: 3-bit adder slice model on the slc_* ports, a phase/arithmetic
// reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_adder_slice_seq;

    localparam int SLICE  = 3;
    localparam int NSLICE = 4;
    localparam int W      = SLICE * NSLICE;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic [SLICE-1:0] slc_a;
    logic [SLICE-1:0] slc_b;
    logic         slc_cin;
    logic [SLICE-1:0] slc_sum;
    logic         slc_cout;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    adder_slice_seq #(.SLICE(SLICE), .NSLICE(NSLICE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout),
        .slc_a(slc_a), .slc_b(slc_b), .slc_cin(slc_cin),
        .slc_sum(slc_sum), .slc_cout(slc_cout)
    );

    always #5 clk = ~clk;

    // external combinational ripple-carry slice
    assign {slc_cout, slc_sum} = {1'b0, slc_a} + {1'b0, slc_b} + {3'b000, slc_cin};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: phase 0 idle, 1..NSLICE run cycles, NSLICE+1 done
    int          m_phase = 0;
    int unsigned m_a = 0, m_b = 0, m_cin = 0, m_hold = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_a     <= 0;
            m_b     <= 0;
            m_cin   <= 0;
            m_hold  <= 0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_a     <= 32'(a);
                m_b     <= 32'(b);
                m_cin   <= 32'(cin);
                m_hold  <= 0;
                m_phase <= 1;
            end
        end else if (m_phase == NSLICE) begin
            m_hold  <= m_a + m_b + m_cin;
            m_phase <= NSLICE + 1;
        end else if (m_phase == NSLICE + 1) begin
            m_phase <= 0;
        end else begin
            m_phase <= m_phase + 1;
        end
    end

    int unsigned k, msk, e_sum, e_cout, e_busy, e_done, e_sa, e_sb, e_sc;

    always @(negedge clk) begin
        if (cmp_en) begin
            if (m_phase >= 1 && m_phase <= NSLICE) begin
                k      = SLICE * (m_phase - 1);
                msk    = (32'd1 << k) - 1;
                e_sum  = (m_a + m_b + m_cin) & msk;
                e_cout = 0;
                e_busy = 1;
                e_done = 0;
                e_sa   = (m_a >> k) & 7;
                e_sb   = (m_b >> k) & 7;
                e_sc   = (((m_a & msk) + (m_b & msk) + m_cin) >> k) & 1;
            end else begin
                e_sum  = m_hold & 32'hFFF;
                e_cout = (m_hold >> W) & 1;
                e_busy = 0;
                e_done = (m_phase == NSLICE + 1) ? 1 : 0;
                e_sa   = 0;
                e_sb   = 0;
                e_sc   = 0;
            end
            chk("busy", 32'(busy), e_busy);
            chk("done", 32'(done), e_done);
            chk("sum", 32'(sum), e_sum);
            chk("cout", 32'(cout), e_cout);
            chk("slc_a", 32'(slc_a), e_sa);
            chk("slc_b", 32'(slc_b), e_sb);
            chk("slc_cin", 32'(slc_cin), e_sc);
        end
    end

    logic [SLICE-1:0] rec_a [8];
    logic             rec_cin [8];
    int               rec_n;

    // one start pulse, operands scrambled after acceptance; returns at the done cycle
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                          output int lat, output int bcnt);
        @(posedge clk); #1;
        a = ia; b = ib; cin = ic; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
        lat = 1;
        bcnt = 0;
        rec_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) begin
                bcnt++;
                if (rec_n < 8) begin
                    rec_a[rec_n]   = slc_a;
                    rec_cin[rec_n] = slc_cin;
                    rec_n++;
                end
            end
            if (done) break;
            @(posedge clk);
            lat++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    int lat, bcnt;
    int done_cyc [$];
    logic [W:0] ref_res;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        run_op(12'hFFF, 12'h001, 1'b0, lat, bcnt);
        chk("t1_latency", 32'(lat), 32'd5);
        chk("t1_sum", 32'(sum), 32'h000);
        chk("t1_cout", 32'(cout), 32'd1);

        run_op(12'h5A5, 12'h123, 1'b1, lat, bcnt);
        chk("t2_sum", 32'(sum), 32'h6C9);
        chk("t2_cout", 32'(cout), 32'd0);
        chk("t2_busy_cycles", 32'(bcnt), 32'd4);

        run_op(12'hABC, 12'h000, 1'b0, lat, bcnt);
        chk("t3_run_cycles", 32'(rec_n), 32'd4);
        chk("t3_slc_a0", 32'(rec_a[0]), 32'd4);
        chk("t3_slc_a1", 32'(rec_a[1]), 32'd7);
        chk("t3_slc_a2", 32'(rec_a[2]), 32'd2);
        chk("t3_slc_a3", 32'(rec_a[3]), 32'd5);
        for (int i = 0; i < 4; i++) chk("t3_slc_cin", 32'(rec_cin[i]), 32'd0);
        chk("t3_sum", 32'(sum), 32'hABC);

        // start held high: accepted once every NSLICE+2 cycles
        @(posedge clk); #1;
        a = 12'h001; b = 12'h001; cin = 1'b0; start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) begin
                done_cyc.push_back(c);
                chk("t4_sum", 32'(sum), 32'h002);
                chk("t4_cout", 32'(cout), 32'd0);
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("t4_done_count", 32'(done_cyc.size()), 32'd6);
        for (int i = 1; i < done_cyc.size(); i++)
            chk("t4_period", 32'(done_cyc[i] - done_cyc[i-1]), 32'd6);
        repeat (8) @(posedge clk);

        // reset asserted in the 2nd RUN cycle
        @(posedge clk); #1;
        a = 12'h123; b = 12'h456; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_sum", 32'(sum), 32'd0);
        chk("t5_cout", 32'(cout), 32'd0);
        chk("t5_slc_a", 32'(slc_a), 32'd0);
        chk("t5_slc_b", 32'(slc_b), 32'd0);
        chk("t5_slc_cin", 32'(slc_cin), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t5_no_done", 32'(done), 32'd0);
        end
        run_op(12'h123, 12'h456, 1'b0, lat, bcnt);
        chk("t5_sum_after", 32'(sum), 32'h579);
        chk("t5_cout_after", 32'(cout), 32'd0);

        for (int n = 0; n < 200; n++) begin
            logic [W-1:0] ra, rb;
            logic rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            ref_res = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            run_op(ra, rb, rc, lat, bcnt);
            chk("t6_result", 32'({cout, sum}), 32'(ref_res));
            chk("t6_latency", 32'(lat), 32'd5);
            @(negedge clk);
            chk("t6_done_width", 32'(done), 32'd0);
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
